// File: rtl/crypto_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_acc_pkg
// Description : Shared definitions for the accelerator command responder:
//               engine op encodings, FSM state encoding and the mapping from
//               an op code to its bit in the done/err/pending vectors.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_acc_pkg;

    // Engine operation codes driven on eng_op
    typedef logic [1:0] op_t;
    localparam op_t OP_HASH = 2'd0;
    localparam op_t OP_ENC  = 2'd1;
    localparam op_t OP_DEC  = 2'd2;

    // Sequencer FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_ISSUE    = 2'd1;
    localparam state_t ST_WAIT     = 2'd2;
    localparam state_t ST_COMPLETE = 2'd3;

    // One-hot position of an op inside the 3-bit per-op vectors
    // (bit0 hash, bit1 encrypt, bit2 decrypt).
    function automatic logic [2:0] opBit(input op_t op);
        return 3'b001 << op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : acc_timeout_ctr
// Description : Engine watchdog counter. Cleared while the engine is being
//               launched, counts while the sequencer waits. o_expire is high
//               in the cycle whose clock edge brings the count to TIMEOUT-1,
//               so the sequencer's abort/complete registers change on exactly
//               that edge.
// Ports       : clk, rst_n     - clock, synchronous active-low reset
//               i_clear        - force count to zero
//               i_enable       - advance count by one
//               o_expire       - final counting cycle reached
// Revision    : 1.0 - initial release
// ============================================================================
module acc_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/accel_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : accel_cmd_responder
// Description : Accelerator-side responder for the gp_cpu command interface.
//               Queues hash/encrypt/decrypt requests with their memory index,
//               runs them one at a time on the shared crypto engine over a
//               start/done handshake (fixed priority H > E > D), and reports
//               sticky done and timeout flags per operation.
// Ports       : clk, rst_n              - clock, synchronous active-low reset
//               H_int, E_int, D_int     - one-cycle request pulses
//               index                   - memory index sampled with a request
//               H_done, E_done, D_done  - sticky completion flags
//               err                     - sticky timeout flags {D,E,H}
//               busy                    - work in flight or pending
//               eng_start, eng_abort    - engine launch / abort pulses
//               eng_op, eng_index       - active op and its index
//               eng_done                - engine completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module accel_cmd_responder
    import crypto_acc_pkg::*;
#(
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             H_int,
    input  logic             E_int,
    input  logic             D_int,
    input  logic [IDX_W-1:0] index,
    output logic             H_done,
    output logic             E_done,
    output logic             D_done,
    output logic [2:0]       err,
    output logic             busy,
    output logic             eng_start,
    output logic [1:0]       eng_op,
    output logic [IDX_W-1:0] eng_index,
    input  logic             eng_done,
    output logic             eng_abort
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [2:0]       r_pend;
    logic [IDX_W-1:0] r_idx [3];
    logic [2:0]       r_done;
    logic [2:0]       r_err;
    logic             r_busy;
    logic             r_engStart;
    logic             r_engAbort;
    op_t              r_engOp;
    logic [IDX_W-1:0] r_engIndex;

    logic [2:0]       w_req;
    logic [2:0]       w_pendNext;
    logic [2:0]       w_selMask;
    logic [2:0]       w_actMask;
    logic [2:0]       w_doneSet;
    op_t              w_sel;
    logic [IDX_W-1:0] w_selIdx;
    logic             w_launch;
    logic             w_finish;
    logic             w_timeout;
    logic             w_ctrClear;
    logic             w_ctrEn;
    logic             w_expire;

    assign w_req = {D_int, E_int, H_int};

    // Per-op index slots: a repeat request simply overwrites the slot.
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_idx[gi] <= '0;
            end else if (w_req[gi]) begin
                r_idx[gi] <= index;
            end
        end
    end

    assign w_ctrClear = (r_state == ST_ISSUE);
    assign w_ctrEn    = (r_state == ST_WAIT);

    acc_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_ctrClear),
        .i_enable (w_ctrEn),
        .o_expire (w_expire)
    );

    always_comb begin
        w_stateNext = r_state;
        w_sel       = OP_HASH;
        w_selIdx    = r_idx[0];
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_launch    = 1'b1;
                    w_stateNext = ST_ISSUE;
                    if (r_pend[0]) begin
                        w_sel    = OP_HASH;
                        w_selIdx = r_idx[0];
                    end else if (r_pend[1]) begin
                        w_sel    = OP_ENC;
                        w_selIdx = r_idx[1];
                    end else begin
                        w_sel    = OP_DEC;
                        w_selIdx = r_idx[2];
                    end
                end
            end
            ST_ISSUE: begin
                w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle takes precedence.
                if (eng_done) begin
                    w_finish    = 1'b1;
                    w_stateNext = ST_COMPLETE;
                end else if (w_expire) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_stateNext = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // A request in the same cycle as the pick re-arms the slot.
    assign w_selMask  = w_launch ? opBit(w_sel) : 3'b000;
    assign w_pendNext = (r_pend & ~w_selMask) | w_req;

    // A finishing op that has been requested again stays "not done" until
    // its rerun finishes.
    assign w_actMask = opBit(r_engOp);
    assign w_doneSet = (w_finish && ((w_pendNext & w_actMask) == 3'b000)) ? w_actMask : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
            r_engStart <= 1'b0;
            r_engAbort <= 1'b0;
            r_engOp    <= OP_HASH;
            r_engIndex <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_pend     <= w_pendNext;
            r_done     <= (r_done & ~w_req) | w_doneSet;
            r_err      <= (r_err & ~w_req) | (w_timeout ? w_doneSet : 3'b000);
            r_busy     <= (w_stateNext != ST_IDLE) || (|w_pendNext);
            r_engStart <= w_launch;
            r_engAbort <= w_timeout;
            if (w_launch) begin
                r_engOp    <= w_sel;
                r_engIndex <= w_selIdx;
            end
        end
    end

    assign H_done    = r_done[0];
    assign E_done    = r_done[1];
    assign D_done    = r_done[2];
    assign err       = r_err;
    assign busy      = r_busy;
    assign eng_start = r_engStart;
    assign eng_abort = r_engAbort;
    assign eng_op    = r_engOp;
    assign eng_index = r_engIndex;

endmodule
`default_nettype wire

// File: tb/tb_accel_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_cmd_responder
// Description : Directed bench for accel_cmd_responder. Expected engine
//               launches and aborts are queued by the stimulus; a monitor
//               pops and compares them whenever the DUT pulses eng_start or
//               eng_abort. Flag/busy expectations are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_cmd_responder;

    localparam int IDX_W   = 16;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] idx;
    } launch_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             H_int = 1'b0;
    logic             E_int = 1'b0;
    logic             D_int = 1'b0;
    logic [IDX_W-1:0] index = '0;
    logic             eng_done = 1'b0;
    logic             H_done, E_done, D_done, busy, eng_start, eng_abort;
    logic [2:0]       err;
    logic [1:0]       eng_op;
    logic [IDX_W-1:0] eng_index;

    launch_t    expLaunch [$];
    logic [1:0] expAbort  [$];
    int         nVec = 0;
    int         nMis = 0;

    accel_cmd_responder #(
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .H_int     (H_int),
        .E_int     (E_int),
        .D_int     (D_int),
        .index     (index),
        .H_done    (H_done),
        .E_done    (E_done),
        .D_done    (D_done),
        .err       (err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_op    (eng_op),
        .eng_index (eng_index),
        .eng_done  (eng_done),
        .eng_abort (eng_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        launch_t    e;
        logic [1:0] a;
        if (rst_n && eng_start) begin
            if (expLaunch.size() == 0) begin
                check("eng_start with nothing expected", {31'd0, eng_start}, 32'd0);
            end else begin
                e = expLaunch.pop_front();
                check("launch eng_op", {30'd0, eng_op}, {30'd0, e.op});
                check("launch eng_index", {16'd0, eng_index}, {16'd0, e.idx});
            end
        end
        if (rst_n && eng_abort) begin
            if (expAbort.size() == 0) begin
                check("eng_abort with nothing expected", {31'd0, eng_abort}, 32'd0);
            end else begin
                a = expAbort.pop_front();
                check("abort eng_op", {30'd0, eng_op}, {30'd0, a});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic h, input logic e, input logic d, input logic [15:0] idx);
        H_int = h; E_int = e; D_int = d; index = idx;
        tick(1);
        H_int = 1'b0; E_int = 1'b0; D_int = 1'b0;
    endtask

    task automatic engDone();
        eng_done = 1'b1;
        tick(1);
        eng_done = 1'b0;
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        while (!eng_start && n < 40) begin
            tick(1);
            n++;
        end
        check({name, " eng_start seen"}, {31'd0, eng_start}, 32'd1);
    endtask

    task automatic checkAllZero(input string name);
        check({name, " flags"}, {27'd0, H_done, E_done, D_done, busy, eng_start}, 32'd0);
        check({name, " err"}, {29'd0, err}, 32'd0);
        check({name, " eng_abort"}, {31'd0, eng_abort}, 32'd0);
        check({name, " eng_op"}, {30'd0, eng_op}, 32'd0);
        check({name, " eng_index"}, {16'd0, eng_index}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset
        tick(3);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Single hash: request in cycle 0
        expLaunch.push_back('{op: 2'd0, idx: 16'h0040});
        pulse(1, 0, 0, 16'h0040);                         // cycle 1
        check("T1 busy c1", {31'd0, busy}, 32'd1);
        check("T1 no start c1", {31'd0, eng_start}, 32'd0);
        tick(1);                                          // cycle 2
        check("T1 start c2", {31'd0, eng_start}, 32'd1);
        tick(3);                                          // cycle 5
        engDone();                                        // cycle 6
        check("T1 H_done c6", {31'd0, H_done}, 32'd1);
        check("T1 busy c6", {31'd0, busy}, 32'd1);
        tick(1);                                          // cycle 7
        check("T1 busy c7", {31'd0, busy}, 32'd0);
        check("T1 H_done c7", {31'd0, H_done}, 32'd1);

        // Simultaneous requests
        expLaunch.push_back('{op: 2'd0, idx: 16'h0100});
        expLaunch.push_back('{op: 2'd1, idx: 16'h0200});
        expLaunch.push_back('{op: 2'd2, idx: 16'h0100});
        H_int = 1'b1; D_int = 1'b1; index = 16'h0100;
        tick(1);
        H_int = 1'b0; D_int = 1'b0; E_int = 1'b1; index = 16'h0200;
        tick(1);
        E_int = 1'b0;
        check("T2 H_done cleared", {31'd0, H_done}, 32'd0);
        waitStart("T2 H");
        tick(2);
        engDone();
        check("T2 done after H", {29'd0, D_done, E_done, H_done}, 32'b001);
        waitStart("T2 E");
        tick(2);
        engDone();
        check("T2 done after E", {29'd0, D_done, E_done, H_done}, 32'b011);
        waitStart("T2 D");
        tick(2);
        engDone();
        check("T2 done after D", {29'd0, D_done, E_done, H_done}, 32'b111);
        tick(1);
        check("T2 busy idle", {31'd0, busy}, 32'd0);

        // Re-request of the active op
        expLaunch.push_back('{op: 2'd1, idx: 16'h0010});
        pulse(0, 1, 0, 16'h0010);
        waitStart("T3 first");
        tick(2);
        expLaunch.push_back('{op: 2'd1, idx: 16'h0020});
        pulse(0, 1, 0, 16'h0020);
        check("T3 E_done before done", {31'd0, E_done}, 32'd0);
        engDone();
        check("T3 E_done suppressed", {31'd0, E_done}, 32'd0);
        check("T3 busy rerun", {31'd0, busy}, 32'd1);
        waitStart("T3 second");
        tick(1);
        engDone();
        check("T3 E_done final", {31'd0, E_done}, 32'd1);

        // Timeout
        expLaunch.push_back('{op: 2'd2, idx: 16'h0300});
        expAbort.push_back(2'd2);
        pulse(0, 0, 1, 16'h0300);
        waitStart("T4");
        n = 0;
        while (!eng_abort && n < 20) begin
            tick(1);
            n++;
        end
        check("T4 abort delay", n, 32'd8);
        check("T4 err", {29'd0, err}, 32'b100);
        check("T4 D_done", {31'd0, D_done}, 32'd1);
        tick(1);
        check("T4 abort one cycle", {31'd0, eng_abort}, 32'd0);
        tick(1);
        check("T4 busy idle", {31'd0, busy}, 32'd0);
        expLaunch.push_back('{op: 2'd2, idx: 16'h0301});
        pulse(0, 0, 1, 16'h0301);
        check("T4 err cleared", {29'd0, err}, 32'd0);
        check("T4 D_done cleared", {31'd0, D_done}, 32'd0);
        waitStart("T4 rerun");
        tick(1);
        engDone();
        check("T4 rerun D_done", {31'd0, D_done}, 32'd1);
        check("T4 rerun err", {29'd0, err}, 32'd0);

        // Done on the expiry cycle, then a stray done in IDLE
        expLaunch.push_back('{op: 2'd1, idx: 16'h0400});
        pulse(0, 1, 0, 16'h0400);
        waitStart("T5");
        tick(TIMEOUT - 1);
        engDone();
        check("T5 no abort", {31'd0, eng_abort}, 32'd0);
        check("T5 err", {29'd0, err}, 32'd0);
        check("T5 E_done", {31'd0, E_done}, 32'd1);
        tick(1);
        check("T5 busy idle", {31'd0, busy}, 32'd0);
        engDone();
        check("T5 stray flags", {27'd0, H_done, E_done, D_done, busy, eng_start}, 32'b11100);
        check("T5 stray err", {29'd0, err}, 32'd0);

        // Reset mid-WAIT with E pending
        expLaunch.push_back('{op: 2'd0, idx: 16'h0050});
        pulse(1, 0, 0, 16'h0050);
        waitStart("T6");
        tick(2);
        pulse(0, 1, 0, 16'h0060);
        check("T6 busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checkAllZero("T6 after reset");
        engDone();
        tick(6);
        check("T6 busy after", {31'd0, busy}, 32'd0);
        check("T6 done after", {29'd0, D_done, E_done, H_done}, 32'd0);

        tick(3);
        check("leftover launches", expLaunch.size(), 32'd0);
        check("leftover aborts", expAbort.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
